pic_ctrl_n: RTL and testbench
=============================

PIC_CTRL_N -- requirements
Module: pic_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_IRQ, 8, number of interrupt lines (power of 2, 8..32); IDX_W = log2(NUM_IRQ).
REQ-002 SHALL have parameter VEC_W, 8, vector width (VEC_W > IDX_W).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_wr  in  1  command write strobe, one cycle.
REQ-006 SHALL have port cmd_sel  in  3  0=ICW1, 1=ICW2..4, 2=OCW1, 3=OCW2, 4=OCW3; 5..7 ignored.
REQ-007 SHALL have port cmd_data  in  NUM_IRQ  command word; fields at fixed low bit positions.
REQ-008 SHALL have port rd  in  1  register read strobe.
REQ-009 SHALL have port rd_data  out  NUM_IRQ  read result, registered.
REQ-010 SHALL have port irq  in  NUM_IRQ  interrupt request lines, synchronous to clk.
REQ-011 SHALL have port int_req  out  1  interrupt request to CPU.
REQ-012 SHALL have port int_ack  in  1  acknowledge pulse, one cycle.
REQ-013 SHALL have ports vec_valid  out  1 and vec  out  VEC_W  interrupt vector, valid one cycle.
REQ-014 SHALL have port init_done  out  1  high in READY state.

Function
REQ-015 Init FSM states INIT_ICW2, INIT_ICW3, INIT_ICW4, READY; ICW1 write from any state -> INIT_ICW2.
REQ-016 ICW1 latches LTIM=data[3], SNGL=data[1], IC4=data[0]; sets IMR all ones; clears IRR, ISR, AEOI, poll flag; resets priority (line 0 highest).
REQ-017 ICW2 latches base=data[VEC_W-1:0]; next INIT_ICW3 if SNGL=0, else INIT_ICW4 if IC4=1, else READY.
REQ-018 ICW3 latches cascade config data[7:0]; next INIT_ICW4 if IC4=1, else READY. ICW4 latches AEOI=data[1]; next READY.
REQ-019 OCW1/2/3 writes outside READY SHALL be ignored; OCW1 writes IMR=data.
REQ-020 Edge mode (LTIM=0): IRR bit set on 0->1 of irq vs previous-cycle sample, cleared on acknowledge of that bit. Level mode: IRR = registered irq.
REQ-021 Winner = highest-priority bit of IRR & ~IMR under current rotation; int_req registered, high when winner priority exceeds highest ISR priority (fully nested), else low.
REQ-022 Ack FSM states ACK_IDLE, ACK_OUT; int_ack in ACK_IDLE latches winner, sets its ISR bit (unless AEOI), clears its IRR bit, -> ACK_OUT; int_ack in ACK_OUT ignored.
REQ-023 ACK_OUT: vec_valid=1, vec = {base[VEC_W-1:IDX_W], idx}, exactly 1 cycle after int_ack; -> ACK_IDLE.
REQ-024 No pending request at int_ack: spurious vector idx=NUM_IRQ-1, no ISR change.
REQ-025 OCW2 data[7:5]: 001 non-specific EOI clears highest-priority ISR bit; 011 specific EOI clears ISR[data[IDX_W-1:0]]; other codes per REQ-032/033.
REQ-026 Same-cycle EOI and ack: ISR_next = (ISR & ~eoi_mask) | ack_mask.
REQ-027 OCW3 data[2]=1 arms poll; data[1:0]=10 selects IRR, 11 selects ISR for rd; other values keep selection.
REQ-028 rd: rd_data next cycle = selected register, or, if poll armed, {pending flag at MSB, zeros, idx}; poll read acts as acknowledge (ISR set, IRR cleared) and disarms poll.

Reset
REQ-029 Reset SHALL force INIT_ICW2, ACK_IDLE, IMR all ones, IRR/ISR/base/cascade/LTIM/SNGL/IC4/AEOI zero, selection IRR, poll disarmed, priority line 0 highest.
REQ-030 Reset SHALL drive int_req=0, vec_valid=0, vec=0, rd_data=0, init_done=0; reset mid-ACK_OUT aborts vector.

Configuration
REQ-031 Macro PIC_CTRL_ROTATE_EN SHALL gate rotation support.
REQ-032 With PIC_CTRL_ROTATE_EN: OCW2 101 non-specific EOI + rotate, 111 specific EOI + rotate, 110 set priority; cleared/given line becomes lowest priority next cycle.
REQ-033 Without PIC_CTRL_ROTATE_EN: codes 101/110/111 SHALL have no effect; priority fixed, line 0 highest.

Structure
REQ-034 Package pic_pkg SHALL hold init/ack state enums, cmd_sel codes, OCW2 opcode constants.
REQ-035 Sub-module pic_prio_resolver SHALL compute rotated highest-priority index and valid flag for an NUM_IRQ-wide vector.

Verification
REQ-036 Init ICW1=0x03 (edge, single, IC4), ICW2=0x40, ICW4=0x00, OCW1=0 -> init_done=1 after ICW4, ICW3 skipped.
REQ-037 irq[3] rising, int_ack -> int_req=1, vec=0x43 one cycle after ack, ISR=0x08; OCW2 0x20 -> ISR=0.
REQ-038 irq[5] in service, irq[2] rises -> int_req=1; irq[6] rises -> int_req stays 0.
REQ-039 int_ack with IRR&~IMR=0 -> vec=0x47, ISR unchanged; AEOI=1 ack of irq[1] -> ISR stays 0.
REQ-040 OCW3 0x04, rd with irq[4] pending -> rd_data MSB=1, idx=4, ISR[4]=1; second rd returns ISR/IRR selection.
REQ-041 ROTATE_EN: OCW2 0xA0 after servicing irq[0] -> line 1 highest; simultaneous irq[0], irq[1] -> vec idx=1.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt controller.
// Init/ack FSM states, cmd_sel codes, OCW2 opcodes.
package pic_pkg;

  typedef enum logic [1:0] {
    INIT_ICW2,
    INIT_ICW3,
    INIT_ICW4,
    READY
  } init_st_t;

  typedef enum logic {
    ACK_IDLE,
    ACK_OUT
  } ack_st_t;

  localparam logic [2:0] SEL_ICW1 = 3'd0;
  localparam logic [2:0] SEL_ICW  = 3'd1;
  localparam logic [2:0] SEL_OCW1 = 3'd2;
  localparam logic [2:0] SEL_OCW2 = 3'd3;
  localparam logic [2:0] SEL_OCW3 = 3'd4;

  localparam logic [2:0] OP_NS_EOI  = 3'b001;
  localparam logic [2:0] OP_SP_EOI  = 3'b011;
  localparam logic [2:0] OP_ROT_NS  = 3'b101;
  localparam logic [2:0] OP_SET_PRI = 3'b110;
  localparam logic [2:0] OP_ROT_SP  = 3'b111;

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: line low+1 is highest, line low is lowest.
// Ports: req (request vector), low (lowest line) -> idx, valid.
module pic_prio_resolver #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] low,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] ln;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    ln    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ln = low + IW'(k + 1);
      if (req[ln]) begin
        idx   = ln;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_ctrl_n.sv
// Programmable interrupt controller (8259-style ICW/OCW programming).
// Ports: clk, reset, cmd_wr/sel/data, rd/rd_data, irq, int_req,
// int_ack, vec_valid/vec, init_done. Macro PIC_CTRL_ROTATE_EN
// enables OCW2 rotate / set-priority commands.
module pic_ctrl_n
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_wr,
  input  logic [2:0]         cmd_sel,
  input  logic [NUM_IRQ-1:0] cmd_data,
  input  logic               rd,
  output logic [NUM_IRQ-1:0] rd_data,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               int_req,
  input  logic               int_ack,
  output logic               vec_valid,
  output logic [VEC_W-1:0]   vec,
  output logic               init_done
);

  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam int BH_W  = VEC_W - IDX_W;
  localparam int PZ_W  = NUM_IRQ - 1 - IDX_W;

  init_st_t init_st, init_nx;
  ack_st_t  ack_st, ack_nx;

  logic               ltim, sngl, ic4, aeoi;
  logic [BH_W-1:0]    base_hi;
  logic [7:0]         cascade;
  logic [NUM_IRQ-1:0] imr, irr, isr, irq_q;
  logic [IDX_W-1:0]   low, low_nx;
  logic               sel_isr, poll;

  logic [IDX_W-1:0]   win_idx, isr_idx;
  logic               win_vld, isr_vld;
  logic [IDX_W-1:0]   rank_w, rank_i;
  logic [NUM_IRQ-1:0] ack_mask, eoi_mask;

  logic               ready;
  logic               wr_icw1, wr_icw;
  logic               wr_ocw1, wr_ocw2, wr_ocw3;
  logic               ack_go, poll_go, take;
  logic [2:0]         op;
  logic [IDX_W-1:0]   cmd_idx;

  pic_prio_resolver #(.N(NUM_IRQ), .IW(IDX_W)) u_win (
    .req   (irr & ~imr),
    .low   (low),
    .idx   (win_idx),
    .valid (win_vld)
  );

  pic_prio_resolver #(.N(NUM_IRQ), .IW(IDX_W)) u_isr (
    .req   (isr),
    .low   (low),
    .idx   (isr_idx),
    .valid (isr_vld)
  );

  assign ready   = (init_st == READY);
  assign wr_icw1 = cmd_wr && (cmd_sel == SEL_ICW1);
  assign wr_icw  = cmd_wr && (cmd_sel == SEL_ICW);
  assign wr_ocw1 = cmd_wr && ready && (cmd_sel == SEL_OCW1);
  assign wr_ocw2 = cmd_wr && ready && (cmd_sel == SEL_OCW2);
  assign wr_ocw3 = cmd_wr && ready && (cmd_sel == SEL_OCW3);
  assign op      = cmd_data[7:5];
  assign cmd_idx = cmd_data[IDX_W-1:0];

  assign ack_go  = (ack_st == ACK_IDLE) && int_ack;
  assign poll_go = rd && poll;
  assign take    = ack_go || poll_go;
  assign ack_mask = (take && win_vld) ?
                    (NUM_IRQ'(1) << win_idx) : '0;

  // Rank 0 is the highest-priority line under the current rotation.
  assign rank_w = win_idx - low - IDX_W'(1);
  assign rank_i = isr_idx - low - IDX_W'(1);

  assign init_done = ready;
  assign vec_valid = (ack_st == ACK_OUT);

  always_comb begin
    eoi_mask = '0;
    low_nx   = low;
    if (wr_ocw2) begin
      unique case (1'b1)
        (op == OP_NS_EOI): begin
          if (isr_vld) eoi_mask = NUM_IRQ'(1) << isr_idx;
        end
        (op == OP_SP_EOI): begin
          eoi_mask = NUM_IRQ'(1) << cmd_idx;
        end
`ifdef PIC_CTRL_ROTATE_EN
        (op == OP_ROT_NS): begin
          if (isr_vld) begin
            eoi_mask = NUM_IRQ'(1) << isr_idx;
            low_nx   = isr_idx;
          end
        end
        (op == OP_ROT_SP): begin
          eoi_mask = NUM_IRQ'(1) << cmd_idx;
          low_nx   = cmd_idx;
        end
        (op == OP_SET_PRI): begin
          low_nx = cmd_idx;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    init_nx = init_st;
    if (wr_icw1) begin
      init_nx = INIT_ICW2;
    end else if (wr_icw) begin
      unique case (init_st)
        INIT_ICW2: init_nx = !sngl ? INIT_ICW3 :
                             ic4 ? INIT_ICW4 : READY;
        INIT_ICW3: init_nx = ic4 ? INIT_ICW4 : READY;
        INIT_ICW4: init_nx = READY;
        default:   init_nx = init_st;
      endcase
    end
  end

  always_comb begin
    ack_nx = ack_st;
    unique case (ack_st)
      ACK_IDLE: if (int_ack) ack_nx = ACK_OUT;
      ACK_OUT:  ack_nx = ACK_IDLE;
      default:  ack_nx = ACK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_st <= INIT_ICW2;
      ack_st  <= ACK_IDLE;
    end else begin
      init_st <= init_nx;
      ack_st  <= ack_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ltim    <= 1'b0;
      sngl    <= 1'b0;
      ic4     <= 1'b0;
      aeoi    <= 1'b0;
      base_hi <= '0;
      cascade <= '0;
      imr     <= '1;
      irr     <= '0;
      isr     <= '0;
      irq_q   <= '0;
      low     <= IDX_W'(NUM_IRQ - 1);
      sel_isr <= 1'b0;
      poll    <= 1'b0;
      int_req <= 1'b0;
      vec     <= '0;
      rd_data <= '0;
    end else begin
      irq_q   <= irq;
      int_req <= win_vld && (!isr_vld || (rank_w < rank_i));
      if (ack_go) begin
        vec <= {base_hi,
                win_vld ? win_idx : IDX_W'(NUM_IRQ - 1)};
      end
      if (rd) begin
        rd_data <= poll ? {win_vld, {PZ_W{1'b0}}, win_idx} :
                   sel_isr ? isr : irr;
      end
      if (wr_icw1) begin
        ltim <= cmd_data[3];
        sngl <= cmd_data[1];
        ic4  <= cmd_data[0];
        aeoi <= 1'b0;
        imr  <= '1;
        irr  <= '0;
        isr  <= '0;
        poll <= 1'b0;
        low  <= IDX_W'(NUM_IRQ - 1);
      end else begin
        if (wr_icw && init_st == INIT_ICW2)
          base_hi <= cmd_data[VEC_W-1:IDX_W];
        if (wr_icw && init_st == INIT_ICW3)
          cascade <= cmd_data[7:0];
        if (wr_icw && init_st == INIT_ICW4)
          aeoi <= cmd_data[1];
        if (wr_ocw1)
          imr <= cmd_data;
        if (poll_go)
          poll <= 1'b0;
        if (wr_ocw3) begin
          if (cmd_data[2]) poll <= 1'b1;
          if (cmd_data[1]) sel_isr <= cmd_data[0];
        end
        irr <= ltim ? irq :
               ((irr & ~ack_mask) | (irq & ~irq_q));
        isr <= (isr & ~eoi_mask) | (aeoi ? '0 : ack_mask);
        low <= low_nx;
      end
    end
  end

endmodule

// File: tb/tb_pic_ctrl_n.sv
// Self-checking bench for pic_ctrl_n (NUM_IRQ=8, VEC_W=8).
// Directed scenarios followed by randomized traffic vs a queue model.
module tb_pic_ctrl_n;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_wr;
  logic [2:0] cmd_sel;
  logic [7:0] cmd_data;
  logic       rd;
  logic [7:0] rd_data;
  logic [7:0] irq;
  logic       int_req;
  logic       int_ack;
  logic       vec_valid;
  logic [7:0] vec;
  logic       init_done;

  always #5 clk = ~clk;

  pic_ctrl_n #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_wr    (cmd_wr),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .rd        (rd),
    .rd_data   (rd_data),
    .irq       (irq),
    .int_req   (int_req),
    .int_ack   (int_ack),
    .vec_valid (vec_valid),
    .vec       (vec),
    .init_done (init_done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  bit [7:0] m_irr, m_isr, m_imr, m_prev, m_rd, m_vec, m_base;
  bit       m_ltim, m_aeoi, m_poll, m_sel_isr, m_out, m_ready;
  int       prio[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void prio_reset();
    prio = {};
    for (int k = 0; k < N; k++) prio.push_back(k);
  endfunction

  function automatic int top_of(bit [7:0] v);
    foreach (prio[k]) if (v[prio[k]]) return prio[k];
    return -1;
  endfunction

  function automatic int rank_of(int ln);
    foreach (prio[k]) if (prio[k] == ln) return k;
    return N;
  endfunction

  // Rotate the priority ring until ln sits at the lowest slot.
  function automatic void demote(int ln);
    while (prio[$] != ln) prio.push_back(prio.pop_front());
  endfunction

  function automatic bit exp_req();
    int w = top_of(m_irr & ~m_imr);
    int i = top_of(m_isr);
    return (w >= 0) && (i < 0 || rank_of(w) < rank_of(i));
  endfunction

  task automatic cyc();
    int w, i;
    bit [7:0] am, em;
    w  = top_of(m_irr & ~m_imr);
    am = '0;
    em = '0;
    if (((int_ack && !m_out) || (rd && m_poll)) && w >= 0)
      am[w] = 1'b1;
    if (rd)
      m_rd = m_poll ? ((w >= 0) ? (8'h80 | 8'(w)) : 8'h00) :
             (m_sel_isr ? m_isr : m_irr);
    if (int_ack && !m_out)
      m_vec = {m_base[7:3], (w >= 0) ? 3'(w) : 3'd7};
    if (cmd_wr && cmd_sel == 3'd3 && m_ready) begin
      case (cmd_data[7:5])
        3'd1: begin
          i = top_of(m_isr);
          if (i >= 0) em[i] = 1'b1;
        end
        3'd3: em[cmd_data[2:0]] = 1'b1;
`ifdef PIC_CTRL_ROTATE_EN
        3'd5: begin
          i = top_of(m_isr);
          if (i >= 0) begin
            em[i] = 1'b1;
            demote(i);
          end
        end
        3'd7: begin
          em[cmd_data[2:0]] = 1'b1;
          demote(int'(cmd_data[2:0]));
        end
        3'd6: demote(int'(cmd_data[2:0]));
`endif
        default: ;
      endcase
    end
    if (cmd_wr && cmd_sel == 3'd2 && m_ready) m_imr = cmd_data;
    if (rd && m_poll) m_poll = 1'b0;
    if (cmd_wr && cmd_sel == 3'd4 && m_ready) begin
      if (cmd_data[2]) m_poll = 1'b1;
      if (cmd_data[1]) m_sel_isr = cmd_data[0];
    end
    m_isr  = (m_isr & ~em) | (m_aeoi ? 8'h00 : am);
    m_irr  = m_ltim ? irq : ((m_irr & ~am) | (irq & ~m_prev));
    m_prev = irq;
    m_out  = int_ack && !m_out;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [2:0] s, logic [7:0] d);
    cmd_wr = 1'b1; cmd_sel = s; cmd_data = d;
    cyc();
    cmd_wr = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    chk("vec_valid_hi", vec_valid, 1);
    chk("vec", vec, m_vec);
    cyc();
    chk("vec_valid_lo", vec_valid, 0);
  endtask

  task automatic pulse(logic [7:0] m);
    irq = irq | m;
    cyc();
    irq = irq & ~m;
    cyc();
  endtask

  task automatic chk_req(string tag);
    cyc();
    chk(tag, int_req, exp_req());
  endtask

  task automatic rdchk(string tag);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    chk(tag, rd_data, m_rd);
  endtask

  task automatic init(logic [7:0] i1, logic [7:0] i2,
                      logic [7:0] i4);
    wr(3'd0, i1);
    m_ready = 0; m_irr = 0; m_isr = 0; m_imr = 8'hFF;
    m_aeoi = 0; m_poll = 0; m_ltim = i1[3];
    prio_reset();
    chk("init_icw1", init_done, 0);
    wr(3'd1, i2);
    m_base = i2;
    chk("init_icw2", init_done, 0);
    wr(3'd1, i4);
    m_aeoi  = i4[1];
    m_ready = 1;
    chk("init_icw4", init_done, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_wr = 0; cmd_sel = 0; cmd_data = 0;
    rd = 0; irq = 0; int_ack = 0;
    m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_prev = 0; m_rd = 0;
    m_vec = 0; m_base = 0; m_ltim = 0; m_aeoi = 0; m_poll = 0;
    m_sel_isr = 0; m_out = 0; m_ready = 0;
    prio_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_int_req", int_req, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec", vec, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    cyc();

    // Edge, single, IC4; base 0x40; ICW3 skipped.
    init(8'h03, 8'h40, 8'h00);
    wr(3'd2, 8'h00);

    pulse(8'h08);
    chk_req("req_irq3");
    chk("req_irq3_k", int_req, 1);
    ack();
    chk("vec_43", vec, 8'h43);
    wr(3'd4, 8'h0B);
    rdchk("isr_08");
    chk("isr_08_k", rd_data, 8'h08);
    wr(3'd3, 8'h20);
    rdchk("isr_eoi");
    chk("isr_eoi_k", rd_data, 8'h00);

    // Fully nested: 2 preempts 5, 6 does not.
    pulse(8'h20);
    ack();
    pulse(8'h04);
    chk_req("nest_hi");
    chk("nest_hi_k", int_req, 1);
    ack();
    wr(3'd3, 8'h20);
    pulse(8'h40);
    chk_req("nest_lo");
    chk("nest_lo_k", int_req, 0);
    wr(3'd3, 8'h65);
    chk_req("nest_sp_eoi");
    ack();
    wr(3'd3, 8'h20);

    // Spurious ack with 5 in service.
    pulse(8'h20);
    ack();
    ack();
    chk("spur_47", vec, 8'h47);
    rdchk("spur_isr");
    chk("spur_isr_k", rd_data, 8'h20);
    wr(3'd3, 8'h20);

    // AEOI
    init(8'h03, 8'h40, 8'h02);
    wr(3'd2, 8'h00);
    pulse(8'h02);
    ack();
    chk("aeoi_vec", vec, 8'h41);
    rdchk("aeoi_isr");
    chk("aeoi_isr_k", rd_data, 8'h00);

    // Poll
    init(8'h03, 8'h40, 8'h00);
    wr(3'd2, 8'h00);
    wr(3'd4, 8'h0B);
    wr(3'd4, 8'h04);
    pulse(8'h10);
    rdchk("poll");
    chk("poll_k", rd_data, 8'h84);
    rdchk("poll_after");
    chk("poll_after_k", rd_data, 8'h10);
    wr(3'd3, 8'h20);

    // Rotation on non-specific EOI
    pulse(8'h01);
    ack();
    wr(3'd3, 8'hA0);
    pulse(8'h03);
    ack();
`ifdef PIC_CTRL_ROTATE_EN
    chk("rot_vec_k", vec, 8'h41);
`else
    chk("fixed_vec_k", vec, 8'h40);
`endif
    wr(3'd3, 8'h20);
    wr(3'd3, 8'h20);
    ack();
    wr(3'd3, 8'h20);
    wr(3'd3, 8'h20);
    chk_req("rot_clean");

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      int a = int'($urandom_range(0, 7));
      case (a)
        0, 1, 2: pulse(8'($urandom));
        3: ack();
        4: wr(3'd3, 8'h20);
        5: wr(3'd3, {3'b011, 2'b00, 3'($urandom)});
        6: wr(3'd3, {3'($urandom_range(5, 7)), 2'b00,
                     3'($urandom)});
        default: wr(3'd2, 8'($urandom) & 8'($urandom));
      endcase
      chk_req("rnd_req");
      if (it % 16 == 0) begin
        wr(3'd4, 8'h0B);
        rdchk("rnd_isr");
        wr(3'd4, 8'h0A);
        rdchk("rnd_irr");
      end
    end

    // Reset during ACK_OUT drops the vector.
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    chk("pre_rst_vv", vec_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_abort_vv", vec_valid, 0);
    chk("rst_abort_vec", vec, 0);
    chk("rst_abort_done", init_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
